// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI bus: per-device CS polarity, setup and guard timing.
// Define SPI_ARB_TIMEOUT_EN to add the grant watchdog and the timeout pulse.
module spi_bus_arbiter #(
  parameter int                 NUM_REQ        = 4,
  parameter logic [NUM_REQ-1:0] CS_ACTIVE_HIGH = 4'b0100,
  parameter int                 SETUP_CYCLES   = 2,
  parameter int                 GUARD_CYCLES   = 4,
  parameter int                 TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] m_sclk,
  input  logic [NUM_REQ-1:0] m_mosi,
  output logic [NUM_REQ-1:0] grant,
  output logic               miso_out,
  input  logic               SPIMISO,
  output logic               SPICLK,
  output logic               SPIMOSI,
  output logic [NUM_REQ-1:0] chip_select,
  output logic               busy,
  output logic               timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] CS_IDLE = ~CS_ACTIVE_HIGH;

  typedef enum logic [1:0] {IDLE, SETUP, GRANT, GUARD} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      last_q, last_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [IW-1:0]      win;
  logic               own_req;
  logic               expire;

  assign own_req     = req[owner_q];
  assign grant       = grant_q;
  assign chip_select = cs_q;
  assign SPICLK      = sclk_q;
  assign SPIMOSI     = mosi_q;
  assign busy        = (state_q != IDLE);
  assign miso_out    = SPIMISO;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0]        tcnt_q, tcnt_d;
  logic [NUM_REQ-1:0] blk_q, blk_d;
  logic               to_q;

  assign elig    = req & ~blk_q;
  assign expire  = (state_q == GRANT) && own_req &&
                   (tcnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign timeout = to_q;

  // An aborted requester stays blocked until it has dropped req once.
  always_comb begin
    tcnt_d = '0;
    blk_d  = blk_q & req;
    if (state_q == GRANT && own_req && !expire)
      tcnt_d = tcnt_q + 16'd1;
    if (expire)
      blk_d[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
      blk_q  <= '0;
      to_q   <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      blk_q  <= blk_d;
      to_q   <= expire;
    end
  end
`else
  assign elig    = req;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // First eligible requester after the last owner, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && elig[IW'((int'(last_q) + i) % NUM_REQ)]) begin
        found = 1'b1;
        win   = IW'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    cs_d    = cs_q;
    sclk_d  = 1'b0;
    mosi_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = win;
          last_d  = win;
          cs_d    = CS_IDLE ^ (NUM_REQ'(1) << win);
          cnt_d   = 4'(SETUP_CYCLES - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!own_req) begin
          cs_d    = CS_IDLE;
          cnt_d   = 4'(GUARD_CYCLES - 1);
          state_d = GUARD;
        end else if (cnt_q == 4'd0) begin
          grant_d = NUM_REQ'(1) << owner_q;
          state_d = GRANT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GRANT: begin
        if (!own_req || expire) begin
          grant_d = '0;
          cs_d    = CS_IDLE;
          cnt_d   = 4'(GUARD_CYCLES - 1);
          state_d = GUARD;
        end else begin
          sclk_d = m_sclk[owner_q];
          mosi_d = m_mosi[owner_q];
        end
      end
      GUARD: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      cs_q    <= CS_IDLE;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: vector table plus hand sequences, checked through an expectation queue.
// Build with SPI_ARB_TIMEOUT_EN defined to exercise the watchdog.
module tb_spi_bus_arbiter;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] cs;
    logic       ck;
    logic       mo;
    logic       bz;
    logic       to;
    logic       mi;
  } out_t;

  typedef struct {
    string      name;
    logic [3:0] r;
    logic [3:0] s;
    logic [3:0] m;
    out_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, m_sclk, m_mosi;
  logic [3:0] grant, chip_select;
  logic       miso_out, SPIMISO, SPICLK, SPIMOSI, busy, timeout;

  int   total = 0;
  int   bad   = 0;
  out_t expq[$];
  string nmq[$];
  vec_t tbl[13];

  localparam logic [3:0] CSI = 4'b1011;

  spi_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req),
    .m_sclk(m_sclk), .m_mosi(m_mosi), .grant(grant),
    .miso_out(miso_out), .SPIMISO(SPIMISO),
    .SPICLK(SPICLK), .SPIMOSI(SPIMOSI),
    .chip_select(chip_select), .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic out_t o(input logic [3:0] g, input logic [3:0] cs,
                             input logic ck, input logic mo,
                             input logic bz, input logic to);
    out_t r;
    r.g = g; r.cs = cs; r.ck = ck; r.mo = mo;
    r.bz = bz; r.to = to; r.mi = 1'b0;
    return r;
  endfunction

  task automatic cmp(input string nm, input out_t e);
    out_t a;
    a.g = grant; a.cs = chip_select; a.ck = SPICLK;
    a.mo = SPIMOSI; a.bz = busy; a.to = timeout; a.mi = miso_out;
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got g=%b cs=%b ck=%b mo=%b busy=%b to=%b miso=%b want g=%b cs=%b ck=%b mo=%b busy=%b to=%b miso=%b",
               nm, a.g, a.cs, a.ck, a.mo, a.bz, a.to, a.mi,
               e.g, e.cs, e.ck, e.mo, e.bz, e.to, e.mi);
    end
  endtask

  task automatic step(input string nm, input logic [3:0] r,
                      input logic [3:0] s, input logic [3:0] m,
                      input out_t e);
    out_t ex;
    ex = e;
    req = r; m_sclk = s; m_mosi = m;
    SPIMISO = 1'($urandom);
    ex.mi = SPIMISO;
    expq.push_back(ex);
    nmq.push_back(nm);
    @(posedge clk);
    #1;
    cmp(nmq.pop_front(), expq.pop_front());
  endtask

  task automatic do_reset();
    out_t e;
    req = '0; m_sclk = '0; m_mosi = '0;
    reset = 1'b1;
    #1;
    e = o(4'b0, CSI, 0, 0, 0, 0);
    e.mi = SPIMISO;
    cmp("reset_state", e);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One full transaction for owner k while every other requester stays pending.
  task automatic xact(input int k);
    logic [3:0] mk, ck;
    mk = 4'b0001 << k;
    ck = CSI ^ mk;
    step("rr_cs",    4'hF, 4'h0, 4'h0, o(4'b0, ck, 0, 0, 1, 0));
    step("rr_setup", 4'hF, 4'h0, 4'h0, o(4'b0, ck, 0, 0, 1, 0));
    step("rr_grant", 4'hF, 4'h0, 4'h0, o(mk,   ck, 0, 0, 1, 0));
    step("rr_data0", 4'hF, ~mk,  mk,   o(mk,   ck, 0, 1, 1, 0));
    step("rr_data1", 4'hF, mk,   ~mk,  o(mk,   ck, 1, 0, 1, 0));
    step("rr_rel",   4'hF & ~mk, 4'hF, 4'hF, o(4'b0, CSI, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      step("rr_guard", 4'hF, 4'h0, 4'h0, o(4'b0, CSI, 0, 0, 1, 0));
    step("rr_idle", 4'hF, 4'h0, 4'h0, o(4'b0, CSI, 0, 0, 0, 0));
  endtask

  initial begin
    out_t e;
    reset = 1'b1; req = '0; m_sclk = '0; m_mosi = '0; SPIMISO = 1'b0;

    tbl[0]  = '{"b_cs",      4'h1, 4'h0, 4'h0, o(4'h0, 4'b1010, 0, 0, 1, 0)};
    tbl[1]  = '{"b_setup",   4'h1, 4'h0, 4'h0, o(4'h0, 4'b1010, 0, 0, 1, 0)};
    tbl[2]  = '{"b_grant",   4'h1, 4'h0, 4'h0, o(4'h1, 4'b1010, 0, 0, 1, 0)};
    tbl[3]  = '{"b_ck1",     4'h1, 4'h1, 4'h0, o(4'h1, 4'b1010, 1, 0, 1, 0)};
    tbl[4]  = '{"b_mo1",     4'h1, 4'h0, 4'h1, o(4'h1, 4'b1010, 0, 1, 1, 0)};
    tbl[5]  = '{"b_both",    4'h1, 4'h1, 4'h1, o(4'h1, 4'b1010, 1, 1, 1, 0)};
    tbl[6]  = '{"b_others",  4'h1, 4'hE, 4'hE, o(4'h1, 4'b1010, 0, 0, 1, 0)};
    tbl[7]  = '{"b_release", 4'h0, 4'h1, 4'h1, o(4'h0, CSI, 0, 0, 1, 0)};
    tbl[8]  = '{"b_guard1",  4'h0, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 1, 0)};
    tbl[9]  = '{"b_guard2",  4'h0, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 1, 0)};
    tbl[10] = '{"b_guard3",  4'h0, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 1, 0)};
    tbl[11] = '{"b_idle",    4'h0, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 0, 0)};
    tbl[12] = '{"b_stay",    4'h0, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 0, 0)};

    do_reset();
    foreach (tbl[i])
      step(tbl[i].name, tbl[i].r, tbl[i].s, tbl[i].m, tbl[i].e);

    // Round robin from reset: 0,1,2,3 then 0 again.
    do_reset();
    xact(0); xact(1); xact(2); xact(3); xact(0);

    // Owner 1 drops req during setup: no grant, straight to guard.
    step("sd_cs",   4'b0010, 4'h0, 4'h0, o(4'h0, 4'b1001, 0, 0, 1, 0));
    step("sd_drop", 4'b0000, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      step("sd_guard", 4'b0000, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 1, 0));
    step("sd_idle", 4'b0000, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 0, 0));

    // Reset while owner 3 holds the bus with its clock high.
    step("mr_cs",    4'b1000, 4'h0, 4'h0, o(4'h0, 4'b0011, 0, 0, 1, 0));
    step("mr_setup", 4'b1000, 4'h0, 4'h0, o(4'h0, 4'b0011, 0, 0, 1, 0));
    step("mr_grant", 4'b1000, 4'h0, 4'h0, o(4'h8, 4'b0011, 0, 0, 1, 0));
    step("mr_data",  4'b1000, 4'h8, 4'h8, o(4'h8, 4'b0011, 1, 1, 1, 0));
    #3;
    reset = 1'b1;
    #1;
    e = o(4'h0, CSI, 0, 0, 0, 0);
    e.mi = SPIMISO;
    cmp("mr_async", e);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("mr_cs0",   4'b1001, 4'h0, 4'h0, o(4'h0, 4'b1010, 0, 0, 1, 0));
    step("mr_set0",  4'b1001, 4'h0, 4'h0, o(4'h0, 4'b1010, 0, 0, 1, 0));
    step("mr_gnt0",  4'b1001, 4'h0, 4'h0, o(4'h1, 4'b1010, 0, 0, 1, 0));

`ifdef SPI_ARB_TIMEOUT_EN
    do_reset();
    step("to_cs",    4'b0100, 4'h0, 4'h0, o(4'h0, 4'b1111, 0, 0, 1, 0));
    step("to_setup", 4'b0100, 4'h0, 4'h0, o(4'h0, 4'b1111, 0, 0, 1, 0));
    step("to_grant", 4'b0100, 4'h0, 4'h0, o(4'h4, 4'b1111, 0, 0, 1, 0));
    for (int i = 1; i < 16; i++)
      step("to_hold", 4'b0100, 4'h0, 4'h0, o(4'h4, 4'b1111, 0, 0, 1, 0));
    step("to_pulse", 4'b0110, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 1, 1));
    for (int i = 0; i < 3; i++)
      step("to_guard", 4'b0110, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 1, 0));
    step("to_idle",  4'b0110, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 0, 0));
    step("to_cs1",   4'b0110, 4'h0, 4'h0, o(4'h0, 4'b1001, 0, 0, 1, 0));
    step("to_set1",  4'b0110, 4'h0, 4'h0, o(4'h0, 4'b1001, 0, 0, 1, 0));
    step("to_gnt1",  4'b0110, 4'h0, 4'h0, o(4'h2, 4'b1001, 0, 0, 1, 0));
    step("to_rel1",  4'b0100, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      step("to_guard1", 4'b0100, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 1, 0));
    step("to_idle1", 4'b0100, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 0, 0));
    step("to_block", 4'b0100, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 0, 0));
    step("to_low",   4'b0000, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 0, 0));
    step("to_regnt", 4'b0100, 4'h0, 4'h0, o(4'h0, 4'b1111, 0, 0, 1, 0));
`else
    // Without the watchdog a grant is held for as long as req stays high.
    do_reset();
    step("nh_cs",    4'b0100, 4'h0, 4'h0, o(4'h0, 4'b1111, 0, 0, 1, 0));
    step("nh_setup", 4'b0100, 4'h0, 4'h0, o(4'h0, 4'b1111, 0, 0, 1, 0));
    step("nh_grant", 4'b0100, 4'h0, 4'h0, o(4'h4, 4'b1111, 0, 0, 1, 0));
    for (int i = 0; i < 24; i++)
      step("nh_hold", 4'b0110, 4'h0, 4'h0, o(4'h4, 4'b1111, 0, 0, 1, 0));
    step("nh_rel",   4'b0010, 4'h0, 4'h0, o(4'h0, CSI, 0, 0, 1, 0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
